// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//   Shared definitions for the memory stage: mem_op field positions,
//   access-size encodings, LSU state encodings and a byte-mask helper.
package mem_stage_lsu_pkg;

   // Bit positions inside the 4-bit mem_op bundle {is_load, is_store, size[1:0]}
   localparam int MEM_LOAD    = 3;
   localparam int MEM_STORE   = 2;
   localparam int MEM_SIZE_HI = 1;
   localparam int MEM_SIZE_LO = 0;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2
   } lsu_state_e;

   // Byte-lane mask of an access of the given size, before lane shifting
   function automatic logic [7:0] size_mask(input mem_size_e size);
      logic [7:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_stage_align
//   Combinational lane logic for the memory stage.
//   Ports:
//     addr_lo      in   byte offset of the access within the 64-bit word
//     size         in   access size (B/H/W/D)
//     is_unsigned  in   zero-extend the load result
//     store_data   in   unshifted store value
//     load_data    in   raw 64-bit read data
//     wstrb        out  byte strobes, shifted to the addressed lanes
//     wdata        out  store value shifted to the addressed lanes
//     misalign     out  offset not a multiple of the access size
//     load_result  out  load data shifted down, truncated and extended
module mem_stage_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  addr_lo,
   input  mem_size_e   size,
   input  logic        is_unsigned,
   input  logic [63:0] store_data,
   input  logic [63:0] load_data,
   output logic [7:0]  wstrb,
   output logic [63:0] wdata,
   output logic        misalign,
   output logic [63:0] load_result
);

   logic [5:0]  bit_off;
   logic [63:0] shifted;

   assign bit_off = {addr_lo, 3'b000};

   always_comb begin
      wstrb       = size_mask(size) << addr_lo;
      wdata       = store_data << bit_off;
      shifted     = load_data >> bit_off;
      misalign    = 1'b0;
      load_result = shifted;
      case (size)
         SIZE_B: begin
            load_result = {{56{~is_unsigned & shifted[7]}}, shifted[7:0]};
         end
         SIZE_H: begin
            misalign    = addr_lo[0];
            load_result = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
         end
         SIZE_W: begin
            misalign    = |addr_lo[1:0];
            load_result = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
         end
         default: begin
            // Doubleword fills the register, so signedness has no effect
            misalign    = |addr_lo;
            load_result = shifted;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory stage behind the EX ALU. Non-memory results pass straight to
//   writeback; loads/stores go out over a single-outstanding dmem port.
//   Ports:
//     clk, rst                   clock, asynchronous active-low reset
//     ex_valid/ex_ready          instruction handshake from EX
//     ex_alu_output              writeback value or effective address
//     ex_store_data              rs2 value for stores
//     ex_mem_op                  {is_load, is_store, size[1:0]}
//     ex_mem_unsigned            zero-extend load result
//     ex_rd, ex_rd_wen           destination register and its write enable
//     dmem_req_*/dmem_addr/...   data-memory request (held while stalled)
//     dmem_rvalid, dmem_rdata    load response
//     wb_*                       registered one-cycle result to writeback
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_alu_output,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [3:0]        ex_mem_op,
   input  logic              ex_mem_unsigned,
   input  logic [4:0]        ex_rd,
   input  logic              ex_rd_wen,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_wen,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [7:0]        dmem_wstrb,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic              wb_rd_wen,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_misalign
);

   lsu_state_e        state_reg;
   logic [2:0]        lo_reg;
   mem_size_e         size_reg;
   logic              uns_reg;
   logic [4:0]        rd_reg;
   logic              rd_wen_reg;
   logic              req_wen_reg;
   logic [ADDR_W-1:0] req_addr_reg;
   logic [DATA_W-1:0] req_wdata_reg;
   logic [7:0]        req_wstrb_reg;
   logic              wb_valid_reg;
   logic [4:0]        wb_rd_reg;
   logic              wb_rd_wen_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic              wb_misalign_reg;

   logic       in_idle;
   logic       ex_is_mem;
   logic       ex_is_store_only;
   logic [2:0] al_lo;
   mem_size_e  al_size;
   logic       al_uns;
   logic [7:0] al_wstrb;
   logic [63:0] al_wdata;
   logic       al_misalign;
   logic [63:0] al_load_result;

   assign in_idle   = (state_reg == ST_IDLE);
   assign ex_is_mem = ex_mem_op[MEM_LOAD] | ex_mem_op[MEM_STORE];
   // If both flags are set the op is treated as a load
   assign ex_is_store_only = ex_mem_op[MEM_STORE] & ~ex_mem_op[MEM_LOAD];

   // One align instance is shared: in IDLE it looks at the incoming op
   // (misalign, strobes, store data); afterwards at the latched load.
   always_comb begin
      if (in_idle) begin
         al_lo   = ex_alu_output[2:0];
         al_size = mem_size_e'(ex_mem_op[MEM_SIZE_HI:MEM_SIZE_LO]);
         al_uns  = ex_mem_unsigned;
      end else begin
         al_lo   = lo_reg;
         al_size = size_reg;
         al_uns  = uns_reg;
      end
   end

   mem_stage_align u_align (
      .addr_lo     (al_lo),
      .size        (al_size),
      .is_unsigned (al_uns),
      .store_data  (ex_store_data),
      .load_data   (dmem_rdata),
      .wstrb       (al_wstrb),
      .wdata       (al_wdata),
      .misalign    (al_misalign),
      .load_result (al_load_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         lo_reg          <= '0;
         size_reg        <= SIZE_B;
         uns_reg         <= 1'b0;
         rd_reg          <= '0;
         rd_wen_reg      <= 1'b0;
         req_wen_reg     <= 1'b0;
         req_addr_reg    <= '0;
         req_wdata_reg   <= '0;
         req_wstrb_reg   <= '0;
         wb_valid_reg    <= 1'b0;
         wb_rd_reg       <= '0;
         wb_rd_wen_reg   <= 1'b0;
         wb_data_reg     <= '0;
         wb_misalign_reg <= 1'b0;
      end else begin
         wb_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (ex_valid) begin
                  if (!ex_is_mem || al_misalign) begin
                     // Result is known now: ALU value, or a faulting access
                     wb_valid_reg    <= 1'b1;
                     wb_data_reg     <= ex_alu_output;
                     wb_rd_reg       <= ex_rd;
                     wb_rd_wen_reg   <= ex_rd_wen & ~ex_is_mem;
                     wb_misalign_reg <= ex_is_mem;
                  end else begin
                     req_addr_reg  <= {ex_alu_output[ADDR_W-1:3], 3'b000};
                     req_wen_reg   <= ex_is_store_only;
                     req_wstrb_reg <= ex_is_store_only ? al_wstrb : 8'h00;
                     req_wdata_reg <= ex_is_store_only ? al_wdata : '0;
                     lo_reg        <= ex_alu_output[2:0];
                     size_reg      <= mem_size_e'(ex_mem_op[MEM_SIZE_HI:MEM_SIZE_LO]);
                     uns_reg       <= ex_mem_unsigned;
                     rd_reg        <= ex_rd;
                     rd_wen_reg    <= ex_rd_wen;
                     state_reg     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_req_ready) begin
                  if (req_wen_reg) begin
                     // Stores complete on acceptance and never write rd
                     wb_valid_reg    <= 1'b1;
                     wb_data_reg     <= '0;
                     wb_rd_reg       <= rd_reg;
                     wb_rd_wen_reg   <= 1'b0;
                     wb_misalign_reg <= 1'b0;
                     state_reg       <= ST_IDLE;
                  end else begin
                     state_reg <= ST_WAIT_R;
                  end
               end
            end
            ST_WAIT_R: begin
               if (dmem_rvalid) begin
                  wb_valid_reg    <= 1'b1;
                  wb_data_reg     <= al_load_result;
                  wb_rd_reg       <= rd_reg;
                  wb_rd_wen_reg   <= rd_wen_reg;
                  wb_misalign_reg <= 1'b0;
                  state_reg       <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Decoded from the state register so an async reset drops the request
   // without waiting for a clock edge
   assign ex_ready       = in_idle;
   assign dmem_req_valid = (state_reg == ST_REQ);
   assign dmem_addr      = req_addr_reg;
   assign dmem_wen       = req_wen_reg;
   assign dmem_wdata     = req_wdata_reg;
   assign dmem_wstrb     = req_wstrb_reg;

   assign wb_valid    = wb_valid_reg;
   assign wb_rd       = wb_rd_reg;
   assign wb_rd_wen   = wb_rd_wen_reg;
   assign wb_data     = wb_data_reg;
   assign wb_misalign = wb_misalign_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Self-checking bench: directed cases plus randomized ops, compared
//   against an arithmetic reference model and an expected-result queue.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [63:0] ex_alu_output;
   logic [63:0] ex_store_data;
   logic [3:0]  ex_mem_op;
   logic        ex_mem_unsigned;
   logic [4:0]  ex_rd;
   logic        ex_rd_wen;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_rd_wen;
   logic [63:0] wb_data;
   logic        wb_misalign;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_output(ex_alu_output), .ex_store_data(ex_store_data),
      .ex_mem_op(ex_mem_op), .ex_mem_unsigned(ex_mem_unsigned),
      .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
      .wb_data(wb_data), .wb_misalign(wb_misalign)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        mis;
      logic        chk_data;
      logic        chk_rd;
      int          due;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] last_wb_data = '0;
   logic        last_wb_mis = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic bit ref_misalign(input logic [63:0] a, input logic [1:0] sz);
      return (a % nbytes(sz)) != 0;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                            input logic uns, input logic [63:0] rdata);
      int          off = int'(a % 8);
      int          nb  = nbytes(sz);
      logic [63:0] v   = rdata >> (8 * off);
      logic [63:0] m;
      if (nb < 8) begin
         m = (64'd1 << (8 * nb)) - 64'd1;
         v = v & m;
         if (!uns && v[8 * nb - 1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic logic [7:0] ref_strb(input logic [63:0] a, input logic [1:0] sz);
      logic [15:0] t = ((16'd1 << nbytes(sz)) - 16'd1) << (a % 8);
      return t[7:0];
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] a, input logic [63:0] sd);
      return sd << (8 * (a % 8));
   endfunction

   // ---------------- writeback compare, every cycle ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (expq.size() > 0 && cyc >= expq[0].due) begin
            e = expq.pop_front();
            check("wb_valid", wb_valid, 1'b1);
            if (wb_valid) begin
               check("wb_misalign", wb_misalign, e.mis);
               check("wb_rd_wen", wb_rd_wen, e.rd_wen);
               if (e.chk_data) check("wb_data", wb_data, e.data);
               if (e.chk_rd) check("wb_rd", wb_rd, e.rd);
            end
         end else if (wb_valid) begin
            check("wb_valid_unexpected", wb_valid, 1'b0);
         end
         if (wb_valid) begin
            last_wb_data = wb_data;
            last_wb_mis  = wb_misalign;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic push_exp(input logic [63:0] d, input logic [4:0] rd, input logic rdw,
                           input logic mis, input logic cd, input logic cr);
      exp_t e;
      e.data = d; e.rd = rd; e.rd_wen = rdw; e.mis = mis;
      e.chk_data = cd; e.chk_rd = cr; e.due = cyc + 1;
      expq.push_back(e);
   endtask

   task automatic run_op(input logic [63:0] alu, input logic [63:0] sd, input logic ld,
                         input logic st, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rd, input logic rdw, input int req_dly,
                         input int rv_dly, input logic [63:0] rdata);
      bit mem = ld | st;
      bit mis = mem && ref_misalign(alu, sz);
      ex_alu_output   = alu;
      ex_store_data   = sd;
      ex_mem_op       = {ld, st, sz};
      ex_mem_unsigned = uns;
      ex_rd           = rd;
      ex_rd_wen       = rdw;
      ex_valid        = 1'b1;
      check("ex_ready_idle", ex_ready, 1'b1);
      if (!mem || mis) push_exp(alu, rd, mis ? 1'b0 : rdw, mis, 1'b1, !mis);
      @(negedge clk);
      // Scramble EX inputs so any late use of them shows up
      ex_valid      = 1'b0;
      ex_alu_output = {$urandom, $urandom};
      ex_store_data = {$urandom, $urandom};
      ex_mem_op     = 4'($urandom);
      ex_rd         = 5'($urandom);
      if (!mem || mis) begin
         check("no_dmem_req", dmem_req_valid, 1'b0);
      end else begin
         for (int i = 0; i <= req_dly; i++) begin
            check("req_valid", dmem_req_valid, 1'b1);
            check("ex_ready_busy", ex_ready, 1'b0);
            check("req_addr", dmem_addr, alu & ~64'd7);
            check("req_wen", dmem_wen, st);
            check("req_wstrb", dmem_wstrb, st ? ref_strb(alu, sz) : 8'h00);
            if (st) check("req_wdata", dmem_wdata, ref_wdata(alu, sd));
            dmem_req_ready = (i == req_dly);
            if (st && i == req_dly) push_exp('0, rd, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
         end
         dmem_req_ready = 1'b0;
         check("req_single", dmem_req_valid, 1'b0);
         if (ld) begin
            for (int i = 0; i < rv_dly; i++) begin
               dmem_rdata     = {$urandom, $urandom};
               dmem_req_ready = 1'($urandom);
               @(negedge clk);
               check("req_none_wait", dmem_req_valid, 1'b0);
            end
            dmem_req_ready = 1'b0;
            dmem_rvalid    = 1'b1;
            dmem_rdata     = rdata;
            push_exp(ref_load(alu, sz, uns, rdata), rd, rdw, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            dmem_rvalid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      ex_valid = 1'b0; ex_alu_output = '0; ex_store_data = '0; ex_mem_op = '0;
      ex_mem_unsigned = 1'b0; ex_rd = '0; ex_rd_wen = 1'b0;
      dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ex_ready", ex_ready, 1'b1);
      check("rst_req_valid", dmem_req_valid, 1'b0);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_data", wb_data, 64'h0);
      check("rst_dmem_addr", dmem_addr, 64'h0);
      check("rst_wstrb", dmem_wstrb, 8'h00);
      rst = 1'b1;
      @(negedge clk);

      // Model pins: hand-computed values
      check("model_strb_b", ref_strb(64'h1005, 2'd0), 8'h20);
      check("model_wdata_b", ref_wdata(64'h1005, 64'hAB), 64'h0000_AB00_0000_0000);
      check("model_ld_h_s", ref_load(64'h2006, 2'd1, 1'b0, 64'h8001_0000_0000_0000), 64'hFFFF_FFFF_FFFF_8001);
      check("model_ld_h_u", ref_load(64'h2006, 2'd1, 1'b1, 64'h8001_0000_0000_0000), 64'h8001);
      check("model_ld_w", ref_load(64'h3004, 2'd2, 1'b0, 64'h8000_0000_1234_5678), 64'hFFFF_FFFF_8000_0000);
      check("model_mis_w", 64'(ref_misalign(64'h4002, 2'd2)), 64'd1);
      check("model_mis_d", 64'(ref_misalign(64'h4004, 2'd3)), 64'd1);

      // ALU passthrough, back to back
      for (int i = 1; i <= 3; i++) begin
         ex_alu_output = 64'(i); ex_mem_op = 4'h0; ex_rd = 5'(i); ex_rd_wen = 1'b1;
         ex_valid = 1'b1;
         check("pass_ex_ready", ex_ready, 1'b1);
         push_exp(64'(i), 5'(i), 1'b1, 1'b0, 1'b1, 1'b1);
         @(negedge clk);
      end
      ex_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pass_last", last_wb_data, 64'd3);

      // Directed memory cases
      run_op(64'h1005, 64'hAB, 1'b0, 1'b1, 2'd0, 1'b0, 5'd7, 1'b1, 2, 0, '0);
      run_op(64'h2006, '0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd8, 1'b1, 0, 1, 64'h8001_0000_0000_0000);
      check("ld_h_signed", last_wb_data, 64'hFFFF_FFFF_FFFF_8001);
      run_op(64'h2006, '0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd8, 1'b1, 0, 1, 64'h8001_0000_0000_0000);
      check("ld_h_unsigned", last_wb_data, 64'h8001);
      run_op(64'h3004, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1, 1, 0, 64'h7FFF_FFFF_0000_0000);
      check("ld_w_pos", last_wb_data, 64'h7FFF_FFFF);
      run_op(64'h3004, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1, 0, 2, 64'h8000_0000_0000_0000);
      check("ld_w_neg", last_wb_data, 64'hFFFF_FFFF_8000_0000);
      run_op(64'h4002, '0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 1'b1, 0, 0, '0);
      check("mis_ld_w", last_wb_mis, 1'b1);
      run_op(64'h4004, 64'h55, 1'b0, 1'b1, 2'd3, 1'b0, 5'd11, 1'b1, 0, 0, '0);
      check("mis_st_d", last_wb_mis, 1'b1);

      // Reset while a request is stalled in REQ
      ex_alu_output = 64'h8; ex_mem_op = {1'b1, 1'b0, 2'd3}; ex_rd = 5'd3; ex_rd_wen = 1'b1;
      ex_valid = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      check("rreq_valid", dmem_req_valid, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rreq_drop_now", dmem_req_valid, 1'b0);
      check("rreq_ex_ready", ex_ready, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset in WAIT_R, then a late rvalid that must be ignored
      ex_alu_output = 64'h10; ex_mem_op = {1'b1, 1'b0, 2'd3}; ex_valid = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      check("rw_no_req", dmem_req_valid, 1'b0);
      check("rw_busy", ex_ready, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("rw_ex_ready", ex_ready, 1'b1);
      check("rw_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("rw_idle_after", ex_ready, 1'b1);
      repeat (2) @(negedge clk);

      // Randomized ops
      for (int n = 0; n < 300; n++) begin
         int          kind = $urandom_range(0, 2);
         logic [63:0] a    = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) a[2:0] = a[2:0] & ~((3'd1 << $urandom_range(0, 3)) - 3'd1);
         if ($urandom_range(0, 4) == 0) begin
            // Stray read data while idle must not produce a result
            dmem_rvalid = 1'b1; dmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            dmem_rvalid = 1'b0;
         end
         run_op(a, {$urandom, $urandom}, kind == 1, kind == 2, 2'($urandom),
                1'($urandom), 5'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
      end
      repeat (3) @(negedge clk);
      check("queue_drained", 64'(expq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage directly downstream of the EX-stage ALU.
- Consumes the ALU result as either a writeback value or an effective address, and performs RV64 byte/half/word/double loads and stores over a single-outstanding valid/ready data-memory port.
- Aligns, masks and sign/zero-extends load data, then presents one registered result per instruction to the writeback stage.

Parameters:
- ADDR_W, 64, effective-address width (equals `REG_BUS` width).
- DATA_W, 64, data-memory bus width; fixed at 64, with 8 byte lanes.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (the polarity and synchronicity are fixed for this block)
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  LSU can accept it this cycle
- ex_alu_output  in  64  ALU result: writeback value, or effective address for load/store
- ex_store_data  in  64  rs2 value for stores
- ex_mem_op  in  4  {is_load, is_store, size[1:0]}; size 0=B, 1=H, 2=W, 3=D
- ex_mem_unsigned  in  1  zero-extend the load result
- ex_rd  in  5  destination register
- ex_rd_wen  in  1  writes rd
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts the request
- dmem_addr  out  64  address, 8-byte aligned (low 3 bits zero)
- dmem_wen  out  1  1=store, 0=load
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte strobes
- dmem_rvalid  in  1  load data valid (loads only; stores complete on acceptance)
- dmem_rdata  in  64  load data
- wb_valid  out  1  result valid, single-cycle pulse
- wb_rd  out  5  destination register
- wb_rd_wen  out  1  write enable; forced 0 on a misaligned access
- wb_data  out  64  result
- wb_misalign  out  1  address misaligned for its size

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 except ex_ready=1.
- States: IDLE, REQ, WAIT_R.
- ex_ready=1 only in IDLE. Acceptance = ex_valid & ex_ready.
- Non-memory op accepted in IDLE:
  - Next cycle: wb_valid=1, wb_data=ex_alu_output, wb_rd/wb_rd_wen copied.
  - Stay in IDLE; a new op can be accepted every cycle (latency 1).
- Misalignment rule: address bits not zero for the size (H: a[0]; W: a[1:0]; D: a[2:0]).
  - A misaligned load/store issues no dmem request.
  - Next cycle: wb_valid=1, wb_misalign=1, wb_rd_wen=0, wb_data=ex_alu_output.
- Aligned load/store accepted in IDLE:
  - Latch addr, size, unsigned, rd, wdata; go to REQ.
  - In REQ: dmem_req_valid=1.
  - Request fields: dmem_addr={a[63:3],3'b0}; wstrb = size mask (1/3/F/FF) << a[2:0]; wdata = store_data << (8*a[2:0]).
  - For loads, wstrb=0 and wen=0.
- REQ with dmem_req_ready=1:
  - Store: next cycle wb_valid=1, wb_rd_wen=0; return to IDLE.
  - Load: go to WAIT_R.
- REQ with dmem_req_ready=0: hold every request field stable and stay in REQ.
- WAIT_R with dmem_rvalid=1:
  - sh = dmem_rdata >> (8*a[2:0]); keep the low 8/16/32/64 bits.
  - Sign-extend unless unsigned (D ignores unsigned).
  - Next cycle: wb_valid=1, wb_data=result, wb_rd_wen=latched value; return to IDLE.
- dmem_rvalid outside WAIT_R: ignored.
- Output timing: wb_* are registered; wb_valid is high for exactly one cycle per accepted instruction.
- Reset mid-transaction: abort to IDLE and drop dmem_req_valid immediately; a late rvalid is ignored.
- Per-state coverage of a memory op: exactly one request handshake; no duplicate request.

Decomposition:
- Shared package / defines.v:
  - MEM_OP field indices (`MEM_LOAD`, `MEM_STORE`, `MEM_SIZE`).
  - Size encodings (`SIZE_B`..`SIZE_D`).
  - LSU state encodings.
- One natural sub-module, mem_stage_align:
  - Purely combinational.
  - Computes wstrb, shifted wdata, misalign, and extended load result from (addr[2:0], size, unsigned, data).

Test Plan:
- ALU passthrough: ex_valid for 3 consecutive cycles, alu_output 1,2,3, non-mem -> wb_valid 3 consecutive cycles, wb_data 1,2,3, ex_ready stays 1.
- Store byte:
  - Stimulus: addr 0x1005, data 0xAB, size B, req_ready delayed 2 cycles.
  - Response: dmem_addr 0x1000, wstrb 0x20, wdata[47:40]=0xAB, all fields stable while stalled, one wb_valid with wb_rd_wen=0.
- Signed half load:
  - Stimulus: addr 0x2006, rdata 0x8001_0000_0000_0000, rvalid 3 cycles after accept.
  - Response: wb_data 0xFFFF_FFFF_FFFF_8001.
  - Same with unsigned=1 -> wb_data 0x8001.
- Word load: addr 0x3004, rdata 0x7FFF_FFFF_0000_0000 -> wb_data 0x7FFF_FFFF. Same with rdata[63:32]=0x8000_0000 -> 0xFFFF_FFFF_8000_0000.
- Misaligned: load W at 0x4002 -> no dmem_req_valid, wb_misalign=1, wb_rd_wen=0; store D at 0x4004 -> same result.
- Async reset asserted in WAIT_R, then rvalid after deassert -> state IDLE, dmem_req_valid=0 immediately, late rvalid produces no wb_valid.
